// File: rtl/e203_reset_src.sv
// System reset request source: merges external, watchdog, debug and keyed software
// reset requests into a minimum-width reset pulse with a cooldown gap and cause logging.
module e203_reset_src #(
  parameter int unsigned MIN_PULSE = 16,
  parameter int unsigned COOLDOWN  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       test_mode,
  input  logic       ext_rst_req_i,
  input  logic       wdt_rst_req_i,
  input  logic       dbg_ndm_rst_i,
  input  logic       sw_rst_req_i,
  input  logic [7:0] sw_rst_key_i,
  input  logic       cause_clr_i,
  output logic       rst_req_o,
  output logic [4:0] rst_cause_o,
  output logic [7:0] rst_cnt_o,
  output logic       key_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2,
    COOL   = 2'd3
  } state_e;

  localparam logic [7:0] SW_KEY     = 8'hA5;
  localparam logic [7:0] PULSE_LAST = 8'(MIN_PULSE - 1);
  localparam logic [7:0] COOL_LAST  = 8'(COOLDOWN - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       rst_req_q, rst_req_d;
  logic [4:0] cause_q, cause_d;
  logic [7:0] rst_cnt_q, rst_cnt_d;
  logic       key_err_q, key_err_d;

  logic sw_ok, level_any, valid, enter_assert;

  assign sw_ok     = sw_rst_req_i && (sw_rst_key_i == SW_KEY);
  assign level_any = ext_rst_req_i || wdt_rst_req_i || dbg_ndm_rst_i;
  assign valid     = level_any || sw_ok;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;

    unique case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = ASSERT;
          cnt_d   = '0;
        end
      end
      ASSERT: begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == PULSE_LAST) begin
          if (level_any) begin
            state_d = HOLD;
          end else begin
            state_d = COOL;
            cnt_d   = '0;
          end
        end
      end
      HOLD: begin
        if (!level_any) begin
          state_d = COOL;
          cnt_d   = '0;
        end
      end
      COOL: begin
        cnt_d = cnt_q + 8'd1;
        if (valid) pending_d = 1'b1;
        if (cnt_q == COOL_LAST) begin
          // A request landing in the final gap cycle must not be lost on the way to IDLE.
          if (pending_q || valid) begin
            state_d = ASSERT;
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    enter_assert = (state_d == ASSERT) && (state_q != ASSERT);
    if (enter_assert) pending_d = 1'b0;

    rst_req_d = (state_d == ASSERT) || (state_d == HOLD);
    rst_cnt_d = (enter_assert && rst_cnt_q != 8'hFF) ? rst_cnt_q + 8'd1 : rst_cnt_q;
    cause_d   = (cause_clr_i ? 5'b00000 : cause_q)
              | {dbg_ndm_rst_i, sw_ok, wdt_rst_req_i, ext_rst_req_i, 1'b0};
    key_err_d = sw_rst_req_i && (sw_rst_key_i != SW_KEY);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pending_q <= 1'b0;
      rst_req_q <= 1'b0;
      cause_q   <= 5'b00001;
      rst_cnt_q <= '0;
      key_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      rst_req_q <= rst_req_d;
      cause_q   <= cause_d;
      rst_cnt_q <= rst_cnt_d;
      key_err_q <= key_err_d;
    end
  end

  // DFT mode masks the request without disturbing the sequencing behind it.
  assign rst_req_o   = rst_req_q && !test_mode;
  assign rst_cause_o = cause_q;
  assign rst_cnt_o   = rst_cnt_q;
  assign key_err_o   = key_err_q;

endmodule

// File: tb/tb_e203_reset_src.sv
// Directed self-checking bench for e203_reset_src with hand-computed expectations.
module tb_e203_reset_src;

  logic       clk = 1'b0;
  logic       rst;
  logic       test_mode;
  logic       ext_rst_req_i, wdt_rst_req_i, dbg_ndm_rst_i, sw_rst_req_i, cause_clr_i;
  logic [7:0] sw_rst_key_i;
  logic       rst_req_o;
  logic [4:0] rst_cause_o;
  logic [7:0] rst_cnt_o;
  logic       key_err_o;

  int checks = 0;
  int errors = 0;

  e203_reset_src #(.MIN_PULSE(16), .COOLDOWN(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .test_mode     (test_mode),
    .ext_rst_req_i (ext_rst_req_i),
    .wdt_rst_req_i (wdt_rst_req_i),
    .dbg_ndm_rst_i (dbg_ndm_rst_i),
    .sw_rst_req_i  (sw_rst_req_i),
    .sw_rst_key_i  (sw_rst_key_i),
    .cause_clr_i   (cause_clr_i),
    .rst_req_o     (rst_req_o),
    .rst_cause_o   (rst_cause_o),
    .rst_cnt_o     (rst_cnt_o),
    .key_err_o     (key_err_o)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Counts consecutive samples (starting with the current one) with rst_req_o high.
  task automatic count_high(output int n, input int limit);
    n = 0;
    while (rst_req_o === 1'b1 && n < limit) begin
      n++;
      tick();
    end
  endtask

  task automatic count_low(output int n, input int limit);
    n = 0;
    while (rst_req_o !== 1'b1 && n < limit) begin
      n++;
      tick();
    end
  endtask

  initial begin
    int hi, lo, n;
    rst = 1'b1; test_mode = 1'b0;
    ext_rst_req_i = 1'b0; wdt_rst_req_i = 1'b0; dbg_ndm_rst_i = 1'b0;
    sw_rst_req_i = 1'b0; sw_rst_key_i = 8'h00; cause_clr_i = 1'b0;
    #1;
    check("por_req",   rst_req_o,   1'b0);
    check("por_cause", rst_cause_o, 5'b00001);
    check("por_cnt",   rst_cnt_o,   8'd0);
    check("por_kerr",  key_err_o,   1'b0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();

    // Keyed software pulse from IDLE: 16-cycle request starting next cycle.
    check("sw_pre_req", rst_req_o, 1'b0);
    sw_rst_req_i = 1'b1; sw_rst_key_i = 8'hA5;
    tick();
    sw_rst_req_i = 1'b0; sw_rst_key_i = 8'h00;
    check("sw_first_req", rst_req_o, 1'b1);
    check("sw_cause", rst_cause_o, 5'b01001);
    check("sw_cnt",   rst_cnt_o,   8'd1);
    count_high(hi, 100);
    check("sw_pulse_len", hi, 16);
    repeat (6) tick();

    // Fresh power-on, then watchdog held 40 cycles: ASSERT + HOLD, then cooldown.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    wdt_rst_req_i = 1'b1;
    hi = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rst_req_o === 1'b1) hi++;
    end
    wdt_rst_req_i = 1'b0;
    check("wdt_high_len", hi, 40);
    lo = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rst_req_o === 1'b0) lo++;
    end
    check("wdt_low_len", lo, 4);
    check("wdt_cause", rst_cause_o, 5'b00101);
    check("wdt_cnt",   rst_cnt_o,   8'd1);
    repeat (3) tick();

    // EXT and DBG together, then keyed sw pulse 2 cycles into COOL.
    ext_rst_req_i = 1'b1; dbg_ndm_rst_i = 1'b1;
    tick();
    check("ed_cause", rst_cause_o, 5'b10111);
    check("ed_cnt",   rst_cnt_o,   8'd2);
    tick();
    tick();
    ext_rst_req_i = 1'b0; dbg_ndm_rst_i = 1'b0;
    count_high(n, 100);
    check("ed_pulse_len", n + 2, 16);
    lo = 0;
    for (int i = 0; i < 2; i++) begin
      if (rst_req_o === 1'b0) lo++;
      tick();
    end
    sw_rst_req_i = 1'b1; sw_rst_key_i = 8'hA5;
    if (rst_req_o === 1'b0) lo++;
    tick();
    sw_rst_req_i = 1'b0; sw_rst_key_i = 8'h00;
    count_low(n, 20);
    check("cool_gap_len", lo + n, 4);
    check("pend_cnt", rst_cnt_o, 8'd3);
    count_high(hi, 100);
    check("pend_pulse_len", hi, 16);
    check("pend_cause", rst_cause_o, 5'b11111);
    count_low(n, 20);
    check("no_extra_pulse", n, 20);

    // Wrong key: error pulse only.
    sw_rst_req_i = 1'b1; sw_rst_key_i = 8'h5A;
    tick();
    sw_rst_req_i = 1'b0; sw_rst_key_i = 8'h00;
    check("bad_key_err", key_err_o, 1'b1);
    check("bad_key_req", rst_req_o, 1'b0);
    tick();
    check("bad_key_err_end", key_err_o, 1'b0);
    check("bad_key_req2",    rst_req_o, 1'b0);
    check("bad_key_cause",   rst_cause_o, 5'b11111);
    check("bad_key_cnt",     rst_cnt_o,   8'd3);

    // Test mode masks the request; dropping it mid-ASSERT exposes the rest.
    cause_clr_i = 1'b1;
    tick();
    cause_clr_i = 1'b0;
    check("clr_cause", rst_cause_o, 5'b00000);
    test_mode = 1'b1;
    sw_rst_req_i = 1'b1; sw_rst_key_i = 8'hA5;
    tick();
    sw_rst_req_i = 1'b0; sw_rst_key_i = 8'h00;
    check("tm_req",   rst_req_o,   1'b0);
    check("tm_cause", rst_cause_o, 5'b01000);
    check("tm_cnt",   rst_cnt_o,   8'd4);
    lo = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (rst_req_o === 1'b0) lo++;
    end
    check("tm_masked", lo, 4);
    test_mode = 1'b0;
    #1;
    check("tm_drop_req", rst_req_o, 1'b1);
    count_high(hi, 100);
    check("tm_remainder", hi, 12);
    repeat (6) tick();

    // Reset 5 cycles into ASSERT aborts at once.
    sw_rst_req_i = 1'b1; sw_rst_key_i = 8'hA5;
    tick();
    sw_rst_req_i = 1'b0; sw_rst_key_i = 8'h00;
    repeat (4) tick();
    check("mid_req", rst_req_o, 1'b1);
    rst = 1'b1;
    #1;
    check("abort_req",   rst_req_o,   1'b0);
    check("abort_cause", rst_cause_o, 5'b00001);
    check("abort_cnt",   rst_cnt_o,   8'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("after_abort_idle", rst_req_o, 1'b0);

    // Clear together with a watchdog request: the new source wins its bit.
    cause_clr_i = 1'b1; wdt_rst_req_i = 1'b1;
    tick();
    cause_clr_i = 1'b0; wdt_rst_req_i = 1'b0;
    check("clr_wdt_cause", rst_cause_o, 5'b00100);
    check("clr_wdt_cnt",   rst_cnt_o,   8'd1);
    count_high(hi, 100);
    check("clr_wdt_len", hi, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
